hash_table_arbiter: RTL and testbench



---
 rtl/hash_table_arbiter.sv | 127 ++++++++++++
 tb/tb_hash_table_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hash_table_arbiter.sv
// Round-robin sharing of one hash-table command/response port among several clients.
// A registered issue stage drives the table, and an in-order tag FIFO routes each response back to its requester.
module hash_table_arbiter #(
  parameter  int KEY_WIDTH      = 32,
  parameter  int DATA_WIDTH     = 30,
  parameter  int NUM_REQUESTERS = 4,
  parameter  int TAG_FIFO_DEPTH = 16,
  localparam int W              = 2 + KEY_WIDTH + DATA_WIDTH,
  localparam int TW             = $clog2(NUM_REQUESTERS),
  localparam int CW             = $clog2(TAG_FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQUESTERS-1:0]   req_valid_i,
  output logic [NUM_REQUESTERS-1:0]   req_ready_o,
  input  logic [NUM_REQUESTERS*W-1:0] req_data_i,
  output logic [NUM_REQUESTERS-1:0]   rsp_valid_o,
  input  logic [NUM_REQUESTERS-1:0]   rsp_ready_i,
  output logic [W-1:0]                rsp_data_o,
  output logic                        tbl_valid_o,
  input  logic                        tbl_ready_i,
  output logic [W-1:0]                tbl_data_o,
  input  logic                        tbl_valid_i,
  output logic                        tbl_ready_o,
  input  logic [W-1:0]                tbl_data_i,
  output logic [CW-1:0]               outstanding_o,
  output logic                        err_o
);

  localparam int AW = $clog2(TAG_FIFO_DEPTH);

  logic [TW-1:0] last_grant;
  logic [TW-1:0] winner;
  logic [TW-1:0] idx;
  logic          found;
  logic          can_accept;
  logic          accept;

  logic [TW-1:0] tag_mem [TAG_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [TW-1:0] head_tag;

  // Search starts one past the last grant so every client is served in turn.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    idx    = last_grant;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      idx = TW'((int'(last_grant) + i) % NUM_REQUESTERS);
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Depth check uses the registered count, so a same-cycle pop never frees a slot early.
  assign can_accept = (!tbl_valid_o || tbl_ready_i) && (count < CW'(TAG_FIFO_DEPTH));
  assign accept     = found && can_accept;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbl_valid_o <= 1'b0;
      tbl_data_o  <= '0;
      last_grant  <= TW'(NUM_REQUESTERS - 1);
    end else begin
      if (accept) begin
        tbl_valid_o <= 1'b1;
        tbl_data_o  <= req_data_i[int'(winner)*W +: W];
        last_grant  <= winner;
      end else if (tbl_ready_i) begin
        tbl_valid_o <= 1'b0;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign push       = accept;
  assign pop        = tbl_valid_i && tbl_ready_o && !fifo_empty;
  assign head_tag   = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (tbl_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  assign outstanding_o = count;

  // With nothing outstanding the table is always drained, so a stray beat cannot wedge it.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = tbl_data_i;
    tbl_ready_o = 1'b1;
    if (!fifo_empty) begin
      rsp_valid_o[head_tag] = tbl_valid_i;
      tbl_ready_o           = rsp_ready_i[head_tag];
    end
  end

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Directed bench for hash_table_arbiter: arbitration order, issue stall, depth limit,
// response routing with backpressure, unexpected responses and reset.
module tb_hash_table_arbiter;
  localparam int KW = 32;
  localparam int DW = 30;
  localparam int N  = 4;
  localparam int D  = 16;
  localparam int W  = 2 + KW + DW;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_data;
  logic [W-1:0]     rsp_data, tbl_data_o, tbl_data_i;
  logic             tbl_valid_o, tbl_ready_i, tbl_valid_i, tbl_ready_o;
  logic [CW-1:0]    outstanding;
  logic             err;
  int               n_cmp = 0;
  int               n_fail = 0;

  hash_table_arbiter #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUM_REQUESTERS(N), .TAG_FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .tbl_valid_o(tbl_valid_o), .tbl_ready_i(tbl_ready_i), .tbl_data_o(tbl_data_o),
    .tbl_valid_i(tbl_valid_i), .tbl_ready_o(tbl_ready_o), .tbl_data_i(tbl_data_i),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cmd(input logic [1:0] op, input logic [KW-1:0] key, input logic [DW-1:0] d);
    return {op, key, d};
  endfunction

  function automatic logic [W-1:0] rq_cmd(input int r);
    return cmd(2'b10, KW'(r + 32'h100), DW'(r + 100));
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; req_data = '0; rsp_ready = '1;
    tbl_ready_i = 1'b1; tbl_valid_i = 1'b0; tbl_data_i = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_cmp++; if (tbl_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_tbl_valid: got %b want 0", tbl_valid_o); end
    n_cmp++; if (tbl_data_o !== '0) begin n_fail++; $display("FAIL rst_tbl_data: got %h want 0", tbl_data_o); end
    n_cmp++; if (outstanding !== 5'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (tbl_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_tbl_ready: got %b want 1", tbl_ready_o); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single_requester();
    logic [W-1:0] ins, lku, r1, r2;
    ins = cmd(2'b10, 32'h0, 30'd5);
    lku = cmd(2'b01, 32'h0, 30'h0);
    r1  = cmd(2'b10, 32'hCAFE_0001, 30'd77);
    r2  = cmd(2'b01, 32'hCAFE_0002, 30'd5);
    do_reset();
    req_valid = 4'b0100; req_data[2*W +: W] = ins;
    settle();
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready0: got %b want 0100", req_ready); end
    cyc();
    n_cmp++; if (tbl_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid0: got %b want 1", tbl_valid_o); end
    n_cmp++; if (tbl_data_o !== ins) begin n_fail++; $display("FAIL single_data0: got %h want %h", tbl_data_o, ins); end
    n_cmp++; if (outstanding !== 5'd1) begin n_fail++; $display("FAIL single_out1: got %0d want 1", outstanding); end
    req_data[2*W +: W] = lku;
    settle();
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready1: got %b want 0100", req_ready); end
    cyc();
    n_cmp++; if (tbl_data_o !== lku) begin n_fail++; $display("FAIL single_data1: got %h want %h", tbl_data_o, lku); end
    n_cmp++; if (outstanding !== 5'd2) begin n_fail++; $display("FAIL single_out2: got %0d want 2", outstanding); end
    req_valid = '0;
    cyc();
    n_cmp++; if (tbl_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", tbl_valid_o); end
    tbl_valid_i = 1'b1; tbl_data_i = r1; rsp_ready = 4'b1111;
    settle();
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_v1: got %b want 0100", rsp_valid); end
    n_cmp++; if (rsp_data !== r1) begin n_fail++; $display("FAIL single_rsp_d1: got %h want %h", rsp_data, r1); end
    cyc();
    n_cmp++; if (outstanding !== 5'd1) begin n_fail++; $display("FAIL single_out_pop1: got %0d want 1", outstanding); end
    tbl_data_i = r2;
    settle();
    n_cmp++; if (rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_v2: got %b want 0100", rsp_valid); end
    n_cmp++; if (rsp_data !== r2) begin n_fail++; $display("FAIL single_rsp_d2: got %h want %h", rsp_data, r2); end
    cyc();
    n_cmp++; if (outstanding !== 5'd0) begin n_fail++; $display("FAIL single_out_pop2: got %0d want 0", outstanding); end
    tbl_valid_i = 1'b0;
    settle();
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < N; r++) req_data[r*W +: W] = rq_cmd(r);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      settle();
      n_cmp++; if (req_ready !== 4'(1 << (k % N))) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % N))); end
      cyc();
      n_cmp++; if (tbl_data_o !== rq_cmd(k % N)) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", k, tbl_data_o, rq_cmd(k % N)); end
    end
    req_valid = '0;
    n_cmp++; if (outstanding !== 5'd8) begin n_fail++; $display("FAIL rr_outstanding: got %0d want 8", outstanding); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int r = 0; r < N; r++) req_data[r*W +: W] = rq_cmd(r);
    req_valid = 4'b1111;
    cyc();
    n_cmp++; if (tbl_data_o !== rq_cmd(0)) begin n_fail++; $display("FAIL stall_first: got %h want %h", tbl_data_o, rq_cmd(0)); end
    tbl_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready%0d: got %b want 0000", k, req_ready); end
      cyc();
      n_cmp++; if (tbl_valid_o !== 1'b1 || tbl_data_o !== rq_cmd(0)) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h want v=1 d=%h", k, tbl_valid_o, tbl_data_o, rq_cmd(0)); end
    end
    tbl_ready_i = 1'b1;
    settle();
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_release: got %b want 0010", req_ready); end
    cyc();
    req_valid = '0;
    n_cmp++; if (tbl_data_o !== rq_cmd(1)) begin n_fail++; $display("FAIL stall_next: got %h want %h", tbl_data_o, rq_cmd(1)); end
  endtask

  task automatic test_full();
    do_reset();
    req_data[1*W +: W] = rq_cmd(1);
    req_valid = 4'b0010;
    repeat (D) cyc();
    settle();
    n_cmp++; if (outstanding !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", outstanding); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_ready: got %b want 0000", req_ready); end
    tbl_valid_i = 1'b1; tbl_data_i = cmd(2'b11, 32'h5, 30'h5); rsp_ready = 4'b1111;
    settle();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_same_cycle: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL full_rsp: got %b want 0010", rsp_valid); end
    cyc();
    n_cmp++; if (outstanding !== 5'd15) begin n_fail++; $display("FAIL full_pop: got %0d want 15", outstanding); end
    tbl_valid_i = 1'b0;
    settle();
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL full_next_ready: got %b want 0010", req_ready); end
    cyc();
    req_valid = '0;
    n_cmp++; if (outstanding !== 5'd16) begin n_fail++; $display("FAIL full_refill: got %0d want 16", outstanding); end
  endtask

  task automatic test_route_backpressure();
    logic [W-1:0] ra, rb;
    ra = cmd(2'b01, 32'hAAAA_AAAA, 30'h1234);
    rb = cmd(2'b11, 32'hBBBB_BBBB, 30'h0F0F);
    do_reset();
    req_data[1*W +: W] = rq_cmd(1); req_data[3*W +: W] = rq_cmd(3);
    req_valid = 4'b0010;
    cyc();
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    n_cmp++; if (outstanding !== 5'd2) begin n_fail++; $display("FAIL route_count: got %0d want 2", outstanding); end
    tbl_valid_i = 1'b1; tbl_data_i = ra; rsp_ready = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_cmp++; if (tbl_ready_o !== 1'b0) begin n_fail++; $display("FAIL route_bp_ready%0d: got %b want 0", k, tbl_ready_o); end
      n_cmp++; if (rsp_valid !== 4'b0010 || rsp_data !== ra) begin n_fail++; $display("FAIL route_bp_hold%0d: got v=%b d=%h want v=0010 d=%h", k, rsp_valid, rsp_data, ra); end
      cyc();
      n_cmp++; if (outstanding !== 5'd2) begin n_fail++; $display("FAIL route_bp_count%0d: got %0d want 2", k, outstanding); end
    end
    rsp_ready = 4'b1111;
    settle();
    n_cmp++; if (tbl_ready_o !== 1'b1) begin n_fail++; $display("FAIL route_release: got %b want 1", tbl_ready_o); end
    cyc();
    n_cmp++; if (outstanding !== 5'd1) begin n_fail++; $display("FAIL route_pop1: got %0d want 1", outstanding); end
    tbl_data_i = rb;
    settle();
    n_cmp++; if (rsp_valid !== 4'b1000 || rsp_data !== rb) begin n_fail++; $display("FAIL route_second: got v=%b d=%h want v=1000 d=%h", rsp_valid, rsp_data, rb); end
    cyc();
    tbl_valid_i = 1'b0;
    n_cmp++; if (outstanding !== 5'd0) begin n_fail++; $display("FAIL route_pop2: got %0d want 0", outstanding); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL route_err: got %b want 0", err); end
  endtask

  task automatic test_error_and_reset();
    do_reset();
    tbl_valid_i = 1'b1; tbl_data_i = cmd(2'b10, 32'hDEAD, 30'h1); rsp_ready = 4'b0000;
    settle();
    n_cmp++; if (tbl_ready_o !== 1'b1) begin n_fail++; $display("FAIL err_drop_ready: got %b want 1", tbl_ready_o); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL err_no_rsp: got %b want 0000", rsp_valid); end
    cyc();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    tbl_valid_i = 1'b0; rsp_ready = 4'b1111;
    cyc(); cyc();
    n_cmp++; if (err !== 1'b1 || outstanding !== 5'd0) begin n_fail++; $display("FAIL err_sticky: got err=%b out=%0d want err=1 out=0", err, outstanding); end
    for (int r = 0; r < N; r++) req_data[r*W +: W] = rq_cmd(r);
    req_valid = 4'b1111;
    cyc(); cyc();
    #2 reset = 1'b1; req_valid = '0;
    #1;
    n_cmp++; if (tbl_valid_o !== 1'b0 || tbl_data_o !== '0) begin n_fail++; $display("FAIL mid_rst_tbl: got v=%b d=%h want v=0 d=0", tbl_valid_o, tbl_data_o); end
    n_cmp++; if (outstanding !== 5'd0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got out=%0d err=%b want out=0 err=0", outstanding, err); end
    n_cmp++; if (rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_hs: got rsp=%b rdy=%b want 0000/0000", rsp_valid, req_ready); end
    @(posedge clk); #1 reset = 1'b0;
    tbl_valid_i = 1'b1;
    settle();
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL post_rst_rsp: got %b want 0000", rsp_valid); end
    cyc();
    tbl_valid_i = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL post_rst_err: got %b want 1", err); end
  endtask

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_stall();
    test_full();
    test_route_backpressure();
    test_error_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
